// File: rtl/sipo_framed.sv
// Framed serial-to-parallel deserialiser with a valid/ready holding register and a sticky overrun flag.
// Latency: 1 clk from the final beat of a word to data_valid. Optional parity beat: SIPO_PARITY_EN.
// Backpressure: a word completing while the holder is full and not being read is dropped and sets overrun.
module sipo_framed #(
  parameter int  DATA_WIDTH = 8,
  parameter int  LANES      = 1,
  parameter bit  MSB_FIRST  = 1'b1,
  localparam int BEATS      = DATA_WIDTH / LANES,
  localparam int CW         = $clog2(BEATS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  shift_en,
  input  logic [LANES-1:0]      serial_in,
  input  logic                  frame_sync,
  input  logic                  data_ready,
  input  logic                  overrun_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  overrun,
`ifdef SIPO_PARITY_EN
  output logic                  parity_err,
`endif
  output logic [CW-1:0]         beat_count
);

`ifdef SIPO_PARITY_EN
  localparam int LAST = BEATS;
`else
  localparam int LAST = BEATS - 1;
`endif
  localparam logic [CW-1:0] LAST_C = CW'(LAST);
  // After a sync beat the new frame holds one beat, unless one beat is already a whole frame.
  localparam logic [CW-1:0] SYNC_C = (LAST == 0) ? CW'(0) : CW'(1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic [DATA_WIDTH-1:0] word;
  logic                  data_beat;
  logic                  word_done;
  logic                  accept;

  generate
    if (LANES == DATA_WIDTH) begin : g_single_beat
      assign shreg_nxt = serial_in;
    end else if (MSB_FIRST) begin : g_msb_first
      assign shreg_nxt = {shreg[DATA_WIDTH-LANES-1:0], serial_in};
    end else begin : g_lsb_first
      assign shreg_nxt = {serial_in, shreg[DATA_WIDTH-1:LANES]};
    end
  endgenerate

`ifdef SIPO_PARITY_EN
  // The parity beat carries no data, so the word is whatever the shifter already holds.
  assign data_beat = shift_en && (frame_sync || (beat_count != LAST_C));
  assign word      = shreg;
`else
  assign data_beat = shift_en;
  assign word      = shreg_nxt;
`endif

  assign word_done = shift_en && (frame_sync ? (LAST == 0) : (beat_count == LAST_C));
  assign accept    = data_valid && data_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      beat_count <= '0;
    end else begin
      if (data_beat) begin
        shreg <= shreg_nxt;
      end
      if (frame_sync) begin
        beat_count <= shift_en ? SYNC_C : CW'(0);
      end else if (shift_en) begin
        beat_count <= word_done ? CW'(0) : beat_count + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
`ifdef SIPO_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (word_done && (!data_valid || data_ready)) begin
      data_out   <= word;
      data_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
      parity_err <= ^{word, serial_in[0]};
`endif
    end else if (accept) begin
      data_valid <= 1'b0;
    end
  end

  // A drop on the same edge as a clear must still be reported.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (word_done && data_valid && !data_ready) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_framed.sv
// Directed bench for sipo_framed: vector table on an MSB-first 8x1 instance plus hand sequences
// for LSB-first, four-lane, async reset and (with SIPO_PARITY_EN) parity corner cases.
module tb_sipo_framed;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       se = 1'b0, sin = 1'b0, fs = 1'b0, rdy = 1'b0, clr = 1'b0;
  logic       se4 = 1'b0;
  logic [3:0] sin4 = 4'h0;

  logic [7:0] d_m, d_l, d_4;
  logic       v_m, v_l, v_4, o_m, o_l, o_4;
  logic [3:0] c_m, c_l;
  logic [1:0] c_4;
`ifdef SIPO_PARITY_EN
  logic       p_m, p_l, p_4;
`endif

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  sipo_framed #(.DATA_WIDTH(8), .LANES(1), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .shift_en(se), .serial_in(sin), .frame_sync(fs),
    .data_ready(rdy), .overrun_clr(clr), .data_out(d_m), .data_valid(v_m),
    .overrun(o_m),
`ifdef SIPO_PARITY_EN
    .parity_err(p_m),
`endif
    .beat_count(c_m));

  sipo_framed #(.DATA_WIDTH(8), .LANES(1), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .shift_en(se), .serial_in(sin), .frame_sync(fs),
    .data_ready(rdy), .overrun_clr(clr), .data_out(d_l), .data_valid(v_l),
    .overrun(o_l),
`ifdef SIPO_PARITY_EN
    .parity_err(p_l),
`endif
    .beat_count(c_l));

  sipo_framed #(.DATA_WIDTH(8), .LANES(4), .MSB_FIRST(1'b1)) u_l4 (
    .clk(clk), .reset(reset), .shift_en(se4), .serial_in(sin4), .frame_sync(fs),
    .data_ready(rdy), .overrun_clr(clr), .data_out(d_4), .data_valid(v_4),
    .overrun(o_4),
`ifdef SIPO_PARITY_EN
    .parity_err(p_4),
`endif
    .beat_count(c_4));

  typedef struct {
    logic       se;
    logic       s;
    logic       fs;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [7:0] d;
    logic       o;
    logic [3:0] c;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic a_se, input logic a_s, input logic a_fs, input logic a_rdy,
                     input logic a_clr, input logic a_v, input logic [7:0] a_d,
                     input logic a_o, input int a_c);
    vec_t t;
    t.se = a_se; t.s = a_s; t.fs = a_fs; t.rdy = a_rdy; t.clr = a_clr;
    t.v = a_v; t.d = a_d; t.o = a_o; t.c = 4'(a_c);
    tbl.push_back(t);
  endtask

  // Drive one cycle of shared inputs, then sample 1 time unit after the edge.
  task automatic beat(input logic b_se, input logic b_s, input logic b_fs,
                      input logic b_rdy, input logic b_clr);
    se = b_se; sin = b_s; fs = b_fs; rdy = b_rdy; clr = b_clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic w_rdy);
    for (int i = 0; i < 8; i++) beat(1'b1, w[7-i], 1'b0, w_rdy, 1'b0);
  endtask

  task automatic beat4(input logic [3:0] b);
    se4 = 1'b1; sin4 = b; rdy = 1'b1;
    @(posedge clk);
    #1;
    se4 = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, nvec=%0d", nvec);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] w;
    #1;
    chk("reset_data", 32'(d_m), 32'h0);
    chk("reset_valid", 32'(v_m), 32'h0);
    chk("reset_count", 32'(c_m), 32'h0);
    chk("reset_overrun", 32'(o_m), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Four-lane instance: beats A then 5 assemble A5.
    chk("l4_count0", 32'(c_4), 32'h0);
    beat4(4'hA);
    chk("l4_count1", 32'(c_4), 32'h1);
    beat4(4'h5);
`ifdef SIPO_PARITY_EN
    chk("l4_count2", 32'(c_4), 32'h2);
    beat4(4'h0);
    chk("l4_perr", 32'(p_4), 32'h0);
`endif
    chk("l4_count_wrap", 32'(c_4), 32'h0);
    chk("l4_data", 32'(d_4), 32'hA5);
    chk("l4_valid", 32'(v_4), 32'h1);
    beat(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("l4_valid_drop", 32'(v_4), 32'h0);

`ifndef SIPO_PARITY_EN
    // B2 with the consumer always ready.
    w = 8'hB2;
    for (int i = 0; i < 8; i++)
      add(1'b1, w[7-i], 1'b0, 1'b1, 1'b0, i == 7, (i == 7) ? 8'hB2 : 8'h00, 1'b0, (i == 7) ? 0 : i + 1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hB2, 1'b0, 0);
    // 11 then 22 with the consumer stalled: 22 is dropped.
    w = 8'h11;
    for (int i = 0; i < 8; i++)
      add(1'b1, w[7-i], 1'b0, 1'b0, 1'b0, i == 7, (i == 7) ? 8'h11 : 8'hB2, 1'b0, (i == 7) ? 0 : i + 1);
    w = 8'h22;
    for (int i = 0; i < 8; i++)
      add(1'b1, w[7-i], 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, i == 7, (i == 7) ? 0 : i + 1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 0);
    // Three stray bits, then a sync beat of 1 and seven zeros: 80.
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, i + 1);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1);
    for (int i = 0; i < 7; i++)
      add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, i == 6, (i == 6) ? 8'h80 : 8'h11, 1'b0, (i == 6) ? 0 : i + 2);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 1'b0, 0);
    // Sync on what would have been the final beat: no word, new frame starts with a 0.
    for (int i = 0; i < 7; i++) add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 1'b0, i + 1);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 1'b0, 1);
    for (int i = 0; i < 7; i++)
      add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, i == 6, (i == 6) ? 8'h7F : 8'h80, 1'b0, (i == 6) ? 0 : i + 2);
    // Holder full; ready arrives on the completing edge so 3C replaces 7F without overrun.
    w = 8'h3C;
    for (int i = 0; i < 8; i++)
      add(1'b1, w[7-i], 1'b0, i == 7, 1'b0, 1'b1, (i == 7) ? 8'h3C : 8'h7F, 1'b0, (i == 7) ? 0 : i + 1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 0);

    foreach (tbl[i]) begin
      beat(tbl[i].se, tbl[i].s, tbl[i].fs, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("v%0d_valid", i), 32'(v_m), 32'(tbl[i].v));
      chk($sformatf("v%0d_data", i), 32'(d_m), 32'(tbl[i].d));
      chk($sformatf("v%0d_overrun", i), 32'(o_m), 32'(tbl[i].o));
      chk($sformatf("v%0d_count", i), 32'(c_m), 32'(tbl[i].c));
      if (i == 7) chk("lsb_first_data", 32'(d_l), 32'h4D);
    end

    // Async reset mid-frame with a full holder and overrun set.
    send_word(8'h55, 1'b0);
    send_word(8'h66, 1'b0);
    beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_valid", 32'(v_m), 32'h1);
    chk("pre_reset_overrun", 32'(o_m), 32'h1);
    chk("pre_reset_count", 32'(c_m), 32'h2);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_data", 32'(d_m), 32'h0);
    chk("async_reset_valid", 32'(v_m), 32'h0);
    chk("async_reset_overrun", 32'(o_m), 32'h0);
    chk("async_reset_count", 32'(c_m), 32'h0);
    reset = 1'b0;
    send_word(8'hFF, 1'b1);
    chk("post_reset_data", 32'(d_m), 32'hFF);
    chk("post_reset_valid", 32'(v_m), 32'h1);
    chk("post_reset_count", 32'(c_m), 32'h0);
`else
    // 03 with correct even parity, then with a wrong parity bit.
    send_word(8'h03, 1'b1);
    chk("par_count_data_beats", 32'(c_m), 32'h8);
    chk("par_valid_before", 32'(v_m), 32'h0);
    beat(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("par_good_data", 32'(d_m), 32'h03);
    chk("par_good_valid", 32'(v_m), 32'h1);
    chk("par_good_err", 32'(p_m), 32'h0);
    chk("par_good_count", 32'(c_m), 32'h0);
    beat(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("par_valid_drop", 32'(v_m), 32'h0);
    send_word(8'h03, 1'b1);
    beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("par_bad_data", 32'(d_m), 32'h03);
    chk("par_bad_valid", 32'(v_m), 32'h1);
    chk("par_bad_err", 32'(p_m), 32'h1);
    beat(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
